// File: rtl/rpu_pkg.sv
// rpu_pkg
//   Shared definitions for the RPU routing blocks. The defaults here are the
//   values used by the spike arbiter, the axon interface and the controller,
//   so that the source-ID width stays consistent across the routing path.
//
//   Contents:
//     NUM_SRC     : default number of neuron cores feeding the arbiter
//     ID_W        : source-ID width (2**ID_W >= NUM_SRC)
//     CNT_W       : width of the saturating drop counter
//     DROP_MAX    : saturation value of the drop counter for CNT_W
//     out_state_e : state of the arbiter's registered output slot
package rpu_pkg;

  localparam int NUM_SRC = 4;
  localparam int ID_W    = 4;
  localparam int CNT_W   = 8;

  localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

  // EMPTY: no event presented (out_valid = 0)
  // FULL : an event is presented and waits for out_ready
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select
//   Combinational round-robin selector. The request vector is rotated so
//   that position ptr lands at bit 0, the lowest set bit is found, and the
//   resulting offset is mapped back to an absolute requester index.
//
//   Ports:
//     req     in  [NUM_SRC-1:0] : request vector
//     ptr     in  [ID_W-1:0]    : index with highest priority (< NUM_SRC)
//     gnt_idx out [ID_W-1:0]    : selected requester (0 when gnt_any = 0)
//     gnt_any out               : at least one request is set
module rr_priority_select #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  logic [2*NUM_SRC-1:0] req_dbl;
  logic [NUM_SRC-1:0]   rot;
  int                   first;
  int                   sum;

  // Doubling the vector turns the wrap-around rotate into a plain shift:
  // rot[j] = req[(j + ptr) mod NUM_SRC].
  assign req_dbl = {req, req};
  assign rot     = NUM_SRC'(req_dbl >> ptr);

  always_comb begin
    gnt_any = 1'b0;
    first   = 0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (rot[j] && !gnt_any) begin
        gnt_any = 1'b1;
        first   = j;
      end
    end
    // Unrotate: offset from ptr back to absolute index, wrapping once.
    sum = first + int'(ptr);
    if (sum >= NUM_SRC) begin
      sum = sum - NUM_SRC;
    end
    gnt_idx = gnt_any ? ID_W'(sum) : '0;
  end

endmodule

// File: rtl/spike_arbiter.sv
// spike_arbiter
//   Round-robin scheduler sharing the single axon routing path among NUM_SRC
//   neuron cores. One-cycle spike pulses are latched as pending events; one
//   pending event per cycle is granted into a registered output slot that
//   carries the source ID to the axon interface.
//
//   Handshake: an event transfers on a rising edge where out_valid = 1 and
//   out_ready = 1. Once out_valid is raised, out_valid and out_src_id hold
//   until that transfer. out_valid is a register output and never depends
//   combinationally on out_ready; out_ready may depend on out_valid.
//
//   Ports:
//     clk        in                : rising-edge clock
//     rst        in                : synchronous, active-low reset
//     spike_in   in  [NUM_SRC-1:0] : per-core spike pulses
//     enable     in                : 0 blocks new grants (capture continues)
//     out_ready  in                : axon interface accepts the event
//     out_valid  out               : out_src_id holds a granted event
//     out_src_id out [ID_W-1:0]    : index of the granted core
//     pending    out [NUM_SRC-1:0] : latched, not-yet-granted events
//     drop_count out [CNT_W-1:0]   : events lost to overrun, saturating
//     busy       out               : |pending or out_valid
//     dbg_state  out               : output-slot FSM state
module spike_arbiter
  import rpu_pkg::*;
#(
  parameter int NUM_SRC = rpu_pkg::NUM_SRC,
  parameter int ID_W    = rpu_pkg::ID_W,
  parameter int CNT_W   = rpu_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] spike_in,
  input  logic               enable,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [ID_W-1:0]    out_src_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [CNT_W-1:0]   drop_count,
  output logic               busy,
  output out_state_e         dbg_state
);

  // Wide enough to add up to 16 overruns to a saturated counter.
  localparam int                 SUM_W    = CNT_W + 5;
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

  out_state_e         state;
  out_state_e         state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_ptr_nxt;
  logic [NUM_SRC-1:0] pending_nxt;
  logic [ID_W-1:0]    out_src_id_nxt;
  logic [CNT_W-1:0]   drop_count_nxt;

  logic               slot_free;
  logic               do_grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [NUM_SRC-1:0] gnt_mask;
  logic [NUM_SRC-1:0] overrun;
  logic [SUM_W-1:0]   drop_sum;

  rr_priority_select #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_select (
    .req     (pending),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign out_valid = (state == OUT_FULL);
  assign busy      = (|pending) | out_valid;
  assign dbg_state = state;

  // The slot can take a new event when empty or when the presented event is
  // leaving this cycle. Grants use registered pending only, so a spike that
  // arrives this cycle is never granted in the same cycle.
  assign slot_free = !out_valid || out_ready;
  assign do_grant  = slot_free && enable && gnt_any;

  always_comb begin
    gnt_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      gnt_mask[i] = do_grant && (gnt_idx == ID_W'(i));
    end
  end

  // A spike on the granted line re-arms it as a fresh event; a spike on any
  // other line that is still pending is lost.
  assign pending_nxt = (pending & ~gnt_mask) | spike_in;
  assign overrun     = spike_in & pending & ~gnt_mask;

  always_comb begin
    drop_sum = SUM_W'(drop_count);
    for (int i = 0; i < NUM_SRC; i++) begin
      drop_sum = drop_sum + SUM_W'(overrun[i]);
    end
    if (drop_sum > SUM_W'(CNT_MAX)) begin
      drop_count_nxt = CNT_MAX;
    end else begin
      drop_count_nxt = drop_sum[CNT_W-1:0];
    end
  end

  always_comb begin
    rr_ptr_nxt     = rr_ptr;
    out_src_id_nxt = out_src_id;
    if (do_grant) begin
      out_src_id_nxt = gnt_idx;
      if (gnt_idx == ID_W'(NUM_SRC - 1)) begin
        rr_ptr_nxt = '0;
      end else begin
        rr_ptr_nxt = gnt_idx + ID_W'(1);
      end
    end
  end

  // Output-slot FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: begin
        if (do_grant) begin
          state_nxt = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (out_ready && !do_grant) begin
          state_nxt = OUT_EMPTY;
        end
      end
      default: state_nxt = OUT_EMPTY;
    endcase
  end

  // Reset discards everything, including an event mid-handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= OUT_EMPTY;
      rr_ptr     <= '0;
      pending    <= '0;
      out_src_id <= '0;
      drop_count <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      pending    <= pending_nxt;
      out_src_id <= out_src_id_nxt;
      drop_count <= drop_count_nxt;
    end
  end

endmodule
